pwm_adjust_ctrl: RTL
====================

Name: pwm_adjust_ctrl

Overview:
- Front-end controller for the PWM/frequency datapath.
- Turns two raw push-buttons (up, down) and a select switch into saturating step commands on two 4-bit setting registers: duty and frequency.
- Debounces both buttons and edge-detects them. Holding a button auto-repeats the step.
- Outputs drive the duty-cycle generator, the frequency divider and the 7-segment decoder directly.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles before a debounced button level changes (5 ms at 100 MHz).
- REP_DELAY, 50000000: hold cycles before the first auto-repeat step.
- REP_PERIOD, 10000000: cycles between subsequent auto-repeat steps.
- DUTY_INIT, 8: reset/restore value of duty.
- FREQ_INIT, 0: reset/restore value of freq.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: asynchronous active-high reset.
- btn_up, input, 1: raw up button, asynchronous, active-high.
- btn_dn, input, 1: raw down button, asynchronous, active-high.
- sel, input, 1: target select; 0 = duty, 1 = freq.
- duty, output, 4: duty setting.
- freq, output, 4: frequency setting.
- upd, output, 1: one-cycle pulse whenever duty or freq changes value.
- hold, output, 1: high while the FSM is in HOLD_UP or HOLD_DN.

Behaviour:
- Reset (async, rst=1):
  - duty=DUTY_INIT, freq=FREQ_INIT, upd=0, hold=0.
  - Synchronizers and debounced levels = 0.
  - Timers = 0; FSM = IDLE.
- Synchronizer: btn_up and btn_dn each pass through a 2-FF synchronizer. sel is used raw; it is only sampled in the cycle a step is applied.
- Debounce, per button:
  - Counter increments while the synced input differs from the debounced level.
  - Counter clears to 0 when they match.
  - When the counter reaches DEB_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - Rising edge = debounced level 0→1, one-cycle internal pulse.
- FSM states: IDLE, HOLD_UP, HOLD_DN, LOCK.
- IDLE:
  - up edge only: step +1 on the selected register; go to HOLD_UP; load timer with REP_DELAY-1.
  - dn edge only: step -1; go to HOLD_DN; same timer load.
  - Both edges in the same cycle: restore the selected register to its INIT value; go to LOCK.
- HOLD_UP / HOLD_DN:
  - Held button's debounced level falls: go to IDLE, no step.
  - Other button's debounced level rises: restore the selected register to INIT; go to LOCK.
  - Otherwise timer counts down. At 0, apply one step in the held direction, reload REP_PERIOD-1, stay.
- LOCK: no actions until both debounced levels are 0, then go to IDLE.
- Step rules:
  - 4-bit saturating arithmetic: 15+1 stays 15, 0-1 stays 0.
  - A step touches only the register chosen by sel in that cycle.
  - Changing sel mid-hold redirects later repeats to the new target.
- upd is asserted exactly in the cycle after a register takes a new value. There is no pulse when saturation or restore leaves the value unchanged.
- Latency, raw pin to register update: 2 sync cycles + DEB_CYCLES + 1 cycle.
- Register outputs are driven directly from flops; there is no combinational path from inputs to outputs.
- hold = (state==HOLD_UP or state==HOLD_DN), registered.
- rst asserted mid-hold or mid-debounce returns everything to reset values immediately. A button still held after rst release produces a fresh edge once debounced.

Optional Feature:
- Macro: PWM_ADJUST_WRAP_EN.
- Defined: step arithmetic wraps modulo 16 (15+1→0, 0-1→15), and upd pulses on every step.
- Undefined: saturating behaviour as described above.
- Debounce, FSM and restore behaviour are identical in both builds.

Test Plan:
All scenarios use DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5.
1. Reset, then a clean btn_up press of 10 cycles with sel=0 → duty 8→9 at cycle 2+4+1 after the press; one upd pulse; freq stays 0; hold high during the press.
2. btn_up toggled every cycle for 30 cycles (bounce), then released → duty unchanged, no upd.
3. btn_dn held for 40 cycles with sel=1, freq=3 → first step at debounce, repeat 20 cycles later, then every 5 cycles; freq saturates at 0; upd only on the 3→2→1→0 changes.
4. duty=15, sel=0, btn_up pressed → duty stays 15, no upd. With PWM_ADJUST_WRAP_EN defined → duty=0 and upd pulses.
5. Both buttons pressed in the same cycle with sel=0 and duty=3 → duty=8 with one upd pulse; state LOCK until both are released; no further steps while in LOCK.
6. rst pulsed during auto-repeat of btn_up → duty=8, freq=0, hold=0 immediately; with btn_up still held after release, exactly one step occurs after debounce.

Source files
------------

// File: rtl/pwm_adjust_ctrl_if.sv
// rtl/pwm_adjust_ctrl_if.sv - button/select inputs and setting outputs of pwm_adjust_ctrl
// Signals:
//   btn_up, btn_dn : raw push-buttons, asynchronous, active-high
//   sel            : target select, 0 = duty, 1 = freq
//   duty, freq     : 4-bit setting registers
//   upd            : one-cycle pulse when duty or freq changes value
//   hold           : high while a button is held in an auto-repeat state
// Modports: master drives the buttons and select; slave is the controller.
interface pwm_adjust_ctrl_if;
    logic       btn_up;
    logic       btn_dn;
    logic       sel;
    logic [3:0] duty;
    logic [3:0] freq;
    logic       upd;
    logic       hold;

    modport master (
        output btn_up, btn_dn, sel,
        input  duty, freq, upd, hold
    );

    modport slave (
        input  btn_up, btn_dn, sel,
        output duty, freq, upd, hold
    );
endinterface

// File: rtl/pwm_adjust_ctrl.sv
// rtl/pwm_adjust_ctrl.sv - debounced up/down buttons stepping the duty and freq settings
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   io   : pwm_adjust_ctrl_if.slave (btn_up, btn_dn, sel in; duty, freq, upd, hold out)
// Build option: define PWM_ADJUST_WRAP_EN to make steps wrap modulo 16 instead of saturating.
module pwm_adjust_ctrl #(
    parameter int         DEB_CYCLES = 500000,
    parameter int         REP_DELAY  = 50000000,
    parameter int         REP_PERIOD = 10000000,
    parameter logic [3:0] DUTY_INIT  = 4'd8,
    parameter logic [3:0] FREQ_INIT  = 4'd0
) (
    input  logic           clk,
    input  logic           rst,
    pwm_adjust_ctrl_if.slave io
);
    localparam int DW   = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
    localparam int TMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCK} state_t;

    logic          up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
    logic          up_lvl_q, up_lvl_d, dn_lvl_q, dn_lvl_d;
    logic          up_prev_q, dn_prev_q;
    logic [DW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    state_t        state_q, state_d;
    logic [3:0]    duty_q, duty_d, freq_q, freq_d;
    logic          upd_q, upd_d, hold_q, hold_d;
    logic          up_rise, dn_rise;
    logic          do_step, step_up, do_restore;

    // Returns {next_level, next_count}; the level only flips after DEB_CYCLES
    // consecutive cycles of disagreement with the synchronized input.
    function automatic logic [DW:0] deb_next(input logic s, input logic lvl,
                                             input logic [DW-1:0] cnt);
        if (s == lvl)
            deb_next = {lvl, {DW{1'b0}}};
        else if (cnt == DW'(DEB_CYCLES - 1))
            deb_next = {~lvl, {DW{1'b0}}};
        else
            deb_next = {lvl, cnt + DW'(1)};
    endfunction

    function automatic logic [3:0] step_val(input logic [3:0] v, input logic up);
`ifdef PWM_ADJUST_WRAP_EN
        step_val = up ? v + 4'd1 : v - 4'd1;
`else
        if (up)
            step_val = (v == 4'hF) ? v : v + 4'd1;
        else
            step_val = (v == 4'h0) ? v : v - 4'd1;
`endif
    endfunction

    assign up_rise = up_lvl_q & ~up_prev_q;
    assign dn_rise = dn_lvl_q & ~dn_prev_q;

    always_comb begin
        {up_lvl_d, up_cnt_d} = deb_next(up_s2_q, up_lvl_q, up_cnt_q);
        {dn_lvl_d, dn_cnt_d} = deb_next(dn_s2_q, dn_lvl_q, dn_cnt_q);

        state_d    = state_q;
        timer_d    = timer_q;
        duty_d     = duty_q;
        freq_d     = freq_q;
        do_step    = 1'b0;
        step_up    = 1'b0;
        do_restore = 1'b0;

        case (state_q)
            IDLE: begin
                if (up_rise && dn_rise) begin
                    do_restore = 1'b1;
                    state_d    = LOCK;
                end else if (up_rise || dn_rise) begin
                    do_step = 1'b1;
                    step_up = up_rise;
                    state_d = up_rise ? HOLD_UP : HOLD_DN;
                    timer_d = TW'(REP_DELAY - 1);
                end
            end
            HOLD_UP, HOLD_DN: begin
                // Release of the held button wins over everything else.
                if ((state_q == HOLD_UP) ? !up_lvl_q : !dn_lvl_q) begin
                    state_d = IDLE;
                end else if ((state_q == HOLD_UP) ? dn_rise : up_rise) begin
                    do_restore = 1'b1;
                    state_d    = LOCK;
                end else if (timer_q == '0) begin
                    do_step = 1'b1;
                    step_up = (state_q == HOLD_UP);
                    timer_d = TW'(REP_PERIOD - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOCK: begin
                if (!up_lvl_q && !dn_lvl_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // sel is sampled only here, so a mid-hold change redirects later repeats.
        if (do_step) begin
            if (io.sel) freq_d = step_val(freq_q, step_up);
            else        duty_d = step_val(duty_q, step_up);
        end
        if (do_restore) begin
            if (io.sel) freq_d = FREQ_INIT;
            else        duty_d = DUTY_INIT;
        end

        upd_d  = (duty_d != duty_q) || (freq_d != freq_q);
        hold_d = (state_d == HOLD_UP) || (state_d == HOLD_DN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_s1_q   <= 1'b0;
            up_s2_q   <= 1'b0;
            dn_s1_q   <= 1'b0;
            dn_s2_q   <= 1'b0;
            up_lvl_q  <= 1'b0;
            dn_lvl_q  <= 1'b0;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
            up_cnt_q  <= '0;
            dn_cnt_q  <= '0;
            timer_q   <= '0;
            state_q   <= IDLE;
            duty_q    <= DUTY_INIT;
            freq_q    <= FREQ_INIT;
            upd_q     <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            up_s1_q   <= io.btn_up;
            up_s2_q   <= up_s1_q;
            dn_s1_q   <= io.btn_dn;
            dn_s2_q   <= dn_s1_q;
            up_lvl_q  <= up_lvl_d;
            dn_lvl_q  <= dn_lvl_d;
            up_prev_q <= up_lvl_q;
            dn_prev_q <= dn_lvl_q;
            up_cnt_q  <= up_cnt_d;
            dn_cnt_q  <= dn_cnt_d;
            timer_q   <= timer_d;
            state_q   <= state_d;
            duty_q    <= duty_d;
            freq_q    <= freq_d;
            upd_q     <= upd_d;
            hold_q    <= hold_d;
        end
    end

    assign io.duty = duty_q;
    assign io.freq = freq_q;
    assign io.upd  = upd_q;
    assign io.hold = hold_q;
endmodule
